// File: rtl/sqrt_pkg.sv
// Shared constants and FSM encoding for the square-root request arbiter.
package sqrt_pkg;

   localparam int unsigned C_W_DEF = 8;
   localparam int unsigned C_LAT   = 4 * C_W_DEF + 2;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIssue = 2'd1,
      StWait  = 2'd2
   } state_t;

   // Cycles from the SQRT start pulse to its done pulse, for a root width w.
   function automatic int unsigned sqrt_lat(input int unsigned w);
      return 4 * w + 2;
   endfunction

endpackage

// File: rtl/sqrt_arb_if.sv
// Connection between the arbiter core and its round-robin picker.
interface sqrt_arb_if #(
   parameter int unsigned C_N  = 4,
   parameter int unsigned C_IW = 2
);
   logic [C_N-1:0]  reqs;
   logic [C_IW-1:0] last;
   logic [C_N-1:0]  gnt;
   logic [C_IW-1:0] idx;
   logic            any;

   modport master (output reqs, last, input gnt, idx, any);
   modport slave  (input reqs, last, output gnt, idx, any);
endinterface

// File: rtl/sqrt_arb_rr.sv
// Round-robin picker: first requester strictly after LAST, wrapping to LAST itself.
module sqrt_arb_rr #(
   parameter int unsigned C_N  = 4,
   parameter int unsigned C_IW = 2
) (
   sqrt_arb_if.slave rr_if
);

   logic [C_N-1:0]  w_gnt;
   logic [C_IW-1:0] w_idx;
   logic            w_any;

   always_comb begin
      w_gnt = '0;
      w_idx = '0;
      w_any = 1'b0;
      // Upper pass covers (LAST, C_N-1]; lower pass wraps to [0, LAST].
      for (int unsigned j = 0; j < C_N; j++) begin
         if (!w_any && rr_if.reqs[j] && (j > 32'(rr_if.last))) begin
            w_any    = 1'b1;
            w_gnt[j] = 1'b1;
            w_idx    = C_IW'(j);
         end
      end
      for (int unsigned j = 0; j < C_N; j++) begin
         if (!w_any && rr_if.reqs[j] && (j <= 32'(rr_if.last))) begin
            w_any    = 1'b1;
            w_gnt[j] = 1'b1;
            w_idx    = C_IW'(j);
         end
      end
   end

   assign rr_if.gnt = w_gnt;
   assign rr_if.idx = w_idx;
   assign rr_if.any = w_any;

endmodule

// File: rtl/sqrt_arb.sv
// Shares one iterative SQRT unit among C_N requesters with round-robin grants
// and a per-transaction timeout.
module sqrt_arb
   import sqrt_pkg::*;
#(
   parameter  int unsigned C_W  = C_W_DEF,
   parameter  int unsigned C_N  = 4,
   parameter  int unsigned C_TO = sqrt_lat(C_W) + 6,
   localparam int unsigned C_IW = (C_N > 1) ? $clog2(C_N) : 1
) (
   input  logic                   CK_i,
   input  logic                   ARST_i,
   input  logic [C_N-1:0]         REQs_i,
   input  logic [C_N*2*C_W-1:0]   DATs_i,
   output logic [C_N-1:0]         ACKs_o,
   output logic [C_W-1:0]         QQs_o,
   output logic [C_IW-1:0]        RIDs_o,
   output logic                   DONE_o,
   output logic                   TO_ERR_o,
   output logic                   BUSY_o,
   output logic                   SQ_REQ_o,
   output logic [2*C_W-1:0]       SQ_DATs_o,
   input  logic [C_W-1:0]         SQ_QQs_i,
   input  logic                   SQ_DONE_i
);

   localparam int unsigned C_DW  = 2 * C_W;
   localparam int unsigned C_TOW = $clog2(C_TO + 1);

   state_t            r_state;
   logic [C_IW-1:0]   r_last;
   logic [C_TOW-1:0]  r_toc;
   logic [C_N-1:0]    r_ack;
   logic [C_W-1:0]    r_qq;
   logic [C_IW-1:0]   r_rid;
   logic              r_done;
   logic              r_to;
   logic              r_sq_req;
   logic [C_DW-1:0]   r_sq_dat;

   logic [C_DW-1:0]   w_dat;

   sqrt_arb_if #(.C_N(C_N), .C_IW(C_IW)) u_rr_if ();

   assign u_rr_if.reqs = REQs_i;
   assign u_rr_if.last = r_last;

   sqrt_arb_rr #(.C_N(C_N), .C_IW(C_IW)) u_rr (
      .rr_if (u_rr_if.slave)
   );

   always_comb begin
      w_dat = '0;
      for (int unsigned k = 0; k < C_N; k++) begin
         if (u_rr_if.idx == C_IW'(k)) w_dat = DATs_i[k*C_DW +: C_DW];
      end
   end

   always_ff @(posedge CK_i or posedge ARST_i) begin
      if (ARST_i) begin
         r_state  <= StIdle;
         r_last   <= C_IW'(C_N - 1);
         r_toc    <= '0;
         r_ack    <= '0;
         r_qq     <= '0;
         r_rid    <= '0;
         r_done   <= 1'b0;
         r_to     <= 1'b0;
         r_sq_req <= 1'b0;
         r_sq_dat <= '0;
      end else begin
         r_ack    <= '0;
         r_sq_req <= 1'b0;
         r_done   <= 1'b0;
         r_to     <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (u_rr_if.any) begin
                  r_ack    <= u_rr_if.gnt;
                  r_sq_req <= 1'b1;
                  r_rid    <= u_rr_if.idx;
                  r_last   <= u_rr_if.idx;
                  r_sq_dat <= w_dat;
                  r_state  <= StIssue;
               end
            end
            StIssue: begin
               r_toc   <= '0;
               r_state <= StWait;
            end
            StWait: begin
               r_toc <= r_toc + C_TOW'(1);
               // A done coinciding with the last timeout cycle still wins.
               if (SQ_DONE_i) begin
                  r_qq    <= SQ_QQs_i;
                  r_done  <= 1'b1;
                  r_state <= StIdle;
               end else if (r_toc == C_TOW'(C_TO - 1)) begin
                  r_to    <= 1'b1;
                  r_state <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign ACKs_o    = r_ack;
   assign QQs_o     = r_qq;
   assign RIDs_o    = r_rid;
   assign DONE_o    = r_done;
   assign TO_ERR_o  = r_to;
   assign BUSY_o    = (r_state != StIdle);
   assign SQ_REQ_o  = r_sq_req;
   assign SQ_DATs_o = r_sq_dat;

endmodule
